// File: rtl/intc_pkg.sv
// Shared types and register map for the wb_intc interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    INTC_LEVEL = 2'd0,
    INTC_RISE  = 2'd1,
    INTC_FALL  = 2'd2,
    INTC_BOTH  = 2'd3
  } intc_mode_t;

  // Word indices as decoded from adr[4:2].
  localparam logic [2:0] INTC_STATUS = 3'd0;
  localparam logic [2:0] INTC_ENABLE = 3'd1;
  localparam logic [2:0] INTC_MODE   = 3'd2;
  localparam logic [2:0] INTC_RAW    = 3'd3;
  localparam logic [2:0] INTC_SET    = 3'd4;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/intc_channel.sv
// One interrupt channel: optional input synchronizer, edge/level detector and pending flag.
// WB_INTC_SYNC_EN adds a two-flop synchronizer in front of the detector.
module intc_channel
  import intc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_i,
  input  intc_mode_t mode_i,
  input  logic       clear_i,
  input  logic       set_i,
  output logic       sample_o,
  output logic       pending_o
);

  logic last_q, last_d;
  logic pending_q, pending_d;
  logic event_hit;

`ifdef WB_INTC_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], irq_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sample_o = sync_q[1];
`else
  assign sample_o = irq_i;
`endif

  always_comb begin
    event_hit = 1'b0;
    unique case (mode_i)
      INTC_LEVEL: event_hit = sample_o;
      INTC_RISE:  event_hit = sample_o & ~last_q;
      INTC_FALL:  event_hit = ~sample_o & last_q;
      INTC_BOTH:  event_hit = sample_o ^ last_q;
      default:    event_hit = 1'b0;
    endcase
    // last follows the sample in every mode so a mode change cannot create an edge.
    last_d    = sample_o;
    pending_d = (pending_q & ~clear_i) | event_hit | set_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/wb_intc.sv
// Wishbone B3 interrupt controller: per-channel condition detect, W1C pending, masked outputs.
// WB_INTC_SYNC_EN enables per-input two-flop synchronizers (see intc_channel).
module wb_intc
  import intc_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter logic [31:0] RESET_MODE = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:2]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  input  logic [CHANNELS-1:0] irq_in,
  output logic [CHANNELS-1:0] irq_out,
  output logic                irq_any
);

  localparam int unsigned ModeW = 2 * CHANNELS;

  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [ModeW-1:0]    mode_q, mode_d;

  logic                req, wr;
  logic [31:0]         be, wr_bits, rdata;
  logic [CHANNELS-1:0] clear_vec, set_vec, sample_vec, pending_vec;

  // Partially used bus data and lane mask when CHANNELS < 16.
  logic unused_bits;
  assign unused_bits = ^{wr_bits, be};

  always_comb begin
    // A new access is only accepted once the previous ack has dropped.
    req       = wb_cyc_i & wb_stb_i & ~ack_q;
    wr        = req & wb_we_i;
    be        = lane_mask(wb_sel_i);
    wr_bits   = wb_dat_i & be;
    ack_d     = req;
    enable_d  = enable_q;
    mode_d    = mode_q;
    clear_vec = '0;
    set_vec   = '0;

    if (wr && wb_adr_i == INTC_STATUS) clear_vec = wr_bits[CHANNELS-1:0];
    if (wr && wb_adr_i == INTC_SET)    set_vec   = wr_bits[CHANNELS-1:0];
    if (wr && wb_adr_i == INTC_ENABLE) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (be[i]) enable_d[i] = wb_dat_i[i];
      end
    end
    if (wr && wb_adr_i == INTC_MODE) begin
      for (int unsigned i = 0; i < ModeW; i++) begin
        if (be[i]) mode_d[i] = wb_dat_i[i];
      end
    end

    rdata = 32'h0;
    case (wb_adr_i)
      INTC_STATUS: rdata = 32'(pending_vec);
      INTC_ENABLE: rdata = 32'(enable_q);
      INTC_MODE:   rdata = 32'(mode_q);
      INTC_RAW:    rdata = 32'(sample_vec);
      default:     rdata = 32'h0;
    endcase
    dat_d = (req && !wb_we_i) ? rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      enable_q <= '0;
      mode_q   <= RESET_MODE[ModeW-1:0];
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    intc_channel u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_i     (irq_in[i]),
      .mode_i    (intc_mode_t'(mode_q[2*i +: 2])),
      .clear_i   (clear_vec[i]),
      .set_i     (set_vec[i]),
      .sample_o  (sample_vec[i]),
      .pending_o (pending_vec[i])
    );
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_out  = pending_vec & enable_q;
  assign irq_any  = |irq_out;

endmodule

// File: tb/tb_wb_intc.sv
// Self-checking bench for wb_intc: directed scenarios plus random traffic against a reference model.
module tb_wb_intc;

`ifdef WB_INTC_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:2]  adr;
  logic [31:0] wdat, rdat;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack;
  logic [3:0]  irq_in, irq_out;
  logic        irq_any;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_intc #(
    .CHANNELS   (4),
    .RESET_MODE (32'h55)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .irq_in   (irq_in),
    .irq_out  (irq_out),
    .irq_any  (irq_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference model: register state kept as plain values, updated from the bus rules.
  logic [3:0]  m_pend, m_en, m_last, m_h1, m_h2;
  logic [7:0]  m_mode;
  logic        m_ack;
  logic [31:0] m_rd;

  function automatic logic [3:0] events(input logic [7:0] mode, input logic [3:0] s,
                                        input logic [3:0] l);
    logic [3:0] e;
    e = 4'h0;
    for (int i = 0; i < 4; i++) begin
      case (mode[2*i +: 2])
        2'd0:    e[i] = s[i];
        2'd1:    e[i] = s[i] && !l[i];
        2'd2:    e[i] = !s[i] && l[i];
        default: e[i] = s[i] != l[i];
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] view(input logic [2:0] a, input logic [3:0] p,
                                       input logic [3:0] e, input logic [7:0] m,
                                       input logic [3:0] s);
    case (a)
      3'd0:    return {28'h0, p};
      3'd1:    return {28'h0, e};
      3'd2:    return {24'h0, m};
      3'd3:    return {28'h0, s};
      default: return 32'h0;
    endcase
  endfunction

  logic        m_req, m_wr;
  logic [3:0]  m_samp;
  logic [31:0] m_be, m_wb;
  assign m_req  = cyc && stb && !m_ack;
  assign m_wr   = m_req && we;
  assign m_samp = (Lat == 2) ? m_h2 : irq_in;
  assign m_be   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  assign m_wb   = wdat & m_be;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 4'h0; m_en <= 4'h0; m_mode <= 8'h55; m_last <= 4'h0;
      m_h1 <= 4'h0; m_h2 <= 4'h0; m_ack <= 1'b0; m_rd <= 32'h0;
    end else begin
      m_pend <= (m_pend & ~((m_wr && adr == 3'd0) ? m_wb[3:0] : 4'h0))
              | events(m_mode, m_samp, m_last)
              | ((m_wr && adr == 3'd4) ? m_wb[3:0] : 4'h0);
      if (m_wr && adr == 3'd1) m_en <= (m_en & ~m_be[3:0]) | m_wb[3:0];
      if (m_wr && adr == 3'd2) m_mode <= (m_mode & ~m_be[7:0]) | m_wb[7:0];
      m_rd   <= (m_req && !we) ? view(adr, m_pend, m_en, m_mode, m_samp) : 32'h0;
      m_last <= m_samp;
      m_h2   <= m_h1;
      m_h1   <= irq_in;
      m_ack  <= m_req;
    end
  end

  always @(negedge clk) begin
    check("irq_out", 32'(irq_out), 32'(m_pend & m_en));
    check("irq_any", 32'(irq_any), 32'(|(m_pend & m_en)));
    check("ack", 32'(ack), 32'(m_ack));
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit now, output logic [31:0] q);
    bit got;
    got = 1'b0;
    if (!now) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      got = ack;
    end
    check("ack_seen", 32'(got), 32'd1);
    q = rdat;
    if (!w) check("rdata", q, m_rd);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, 4'hF, 1'b0, q);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'h0, 4'hF, 1'b0, q);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] q;
    int n;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 3'd0; wdat = 32'h0; sel = 4'h0; irq_in = 4'h0;
    idle(3);
    rst_n = 1'b1;

    rd(3'd0, q); check("rst_status", q, 32'h0);
    rd(3'd1, q); check("rst_enable", q, 32'h0);
    rd(3'd2, q); check("rst_mode", q, 32'h55);
    rd(3'd3, q); check("rst_raw", q, 32'h0);
    rd(3'd5, q); check("rd_0x14", q, 32'h0);

    // Rise on ch2, clear, then fall detected once ch2 is switched to BOTH.
    wr(3'd1, 32'hF);
    irq_in[2] = 1'b1; idle(4); irq_in[2] = 1'b0; idle(4);
    rd(3'd0, q); check("rise_status", q, 32'h4);
    check("rise_any", 32'(irq_any), 32'd1);
    wr(3'd0, 32'h4);
    rd(3'd0, q); check("w1c_status", q, 32'h0);
    check("w1c_any", 32'(irq_any), 32'd0);
    irq_in[2] = 1'b1; idle(4);
    wr(3'd0, 32'h4); wr(3'd2, 32'h75);
    irq_in[2] = 1'b0; idle(4);
    rd(3'd0, q); check("both_fall", q, 32'h4);
    wr(3'd0, 32'h4);

    // Mode writes with static inputs must not fabricate events.
    wr(3'd2, 32'h65); idle(4);
    rd(3'd0, q); check("mode_static_lo", q, 32'h0);
    irq_in[1] = 1'b1; idle(4);
    wr(3'd0, 32'hF); wr(3'd2, 32'h7D); idle(4);
    rd(3'd0, q); check("mode_static_hi", q, 32'h0);
    irq_in[1] = 1'b0; idle(4);
    wr(3'd2, 32'h55); wr(3'd0, 32'hF);

    // LEVEL: clearing while input high re-asserts.
    wr(3'd2, 32'h54);
    irq_in[0] = 1'b1; idle(4);
    wr(3'd0, 32'h1);
    rd(3'd0, q); check("level_reassert", q & 32'h1, 32'h1);
    irq_in[0] = 1'b0; idle(4);
    wr(3'd0, 32'h1);
    rd(3'd0, q); check("level_clear", q, 32'h0);
    wr(3'd2, 32'h55);

    // Rising edge on ch1 lands on the same edge as a W1C of ch1.
    @(negedge clk);
    irq_in[1] = 1'b1;
    repeat (Lat) @(negedge clk);
    bus(1'b1, 3'd0, 32'h2, 4'hF, 1'b1, q);
    rd(3'd0, q); check("event_beats_w1c", q & 32'h2, 32'h2);
    irq_in[1] = 1'b0; idle(4);
    wr(3'd0, 32'hF);
    wr(3'd4, 32'h2);
    rd(3'd0, q); check("sw_set", q, 32'h2);
    rd(3'd4, q); check("set_reads0", q, 32'h0);
    wr(3'd0, 32'h2);
    rd(3'd0, q); check("set_cleared", q, 32'h0);

    // Masking: pending latches while disabled; enabling exposes it immediately.
    wr(3'd1, 32'h0);
    irq_in[3] = 1'b1; idle(4);
    rd(3'd0, q); check("mask_status", q, 32'h8);
    check("mask_out", 32'(irq_out), 32'h0);
    wr(3'd1, 32'h8);
    check("unmask_out", 32'(irq_out), 32'h8);
    irq_in[3] = 1'b0; idle(4);
    wr(3'd0, 32'hF); wr(3'd1, 32'hF);

    // Edge-to-pending latency on ch1.
    @(negedge clk);
    irq_in[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (irq_out[1]) break;
    end
    check("latency", 32'(n), 32'(Lat + 1));
    irq_in[1] = 1'b0; idle(4);
    wr(3'd0, 32'hF);

    // Upper bits are not stored; unselected lanes are not written.
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, q); check("enable_masked", q, 32'hF);
    bus(1'b1, 3'd1, 32'h0, 4'b1110, 1'b0, q);
    rd(3'd1, q); check("enable_lanes", q, 32'hF);
    wr(3'd2, 32'hFFFF_FF55);
    rd(3'd2, q); check("mode_masked", q, 32'h55);
    rd(3'd7, q); check("rd_0x1c", q, 32'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        bus(1'($urandom), 3'($urandom), $urandom, 4'($urandom), 1'b0, q);
      else
        @(negedge clk);
    end

    // Reset in the middle of an acknowledged access.
    irq_in = 4'h0; idle(4);
    wr(3'd1, 32'h5); wr(3'd2, 32'hAA);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd1;
    @(posedge clk);
    #1;
    check("ack_before_rst", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ack_dropped", 32'(ack), 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd1, q); check("post_rst_enable", q, 32'h0);
    rd(3'd2, q); check("post_rst_mode", q, 32'h55);
    rd(3'd0, q); check("post_rst_status", q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_intc.md
# wb_intc

Parametrised interrupt controller: a Wishbone B3 slave that collects `CHANNELS` external event lines, detects a per-channel programmable condition (level, rising, falling or any edge), latches pending flags and drives a masked interrupt vector to the processor's `interrupts` input. It replaces the fixed per-line edge and change latches that sit between touch/A-D sources and the CPU; software clears flags through the bus instead of through side-effect strobes.

## Interface
- `CHANNELS`, 4: number of event inputs, 1..16.
- `RESET_MODE`, 32'h0: MODE register reset value, 2 bits per channel.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus` wishbone_b3.slave: register access (`adr`, `dat_i`, `dat_o`, `sel`, `we`, `stb`, `cyc`, `ack`).
- `irq_in` in `CHANNELS`: raw event lines, may be asynchronous.
- `irq_out` out `CHANNELS`: `pending & enable`, per channel.
- `irq_any` out 1: OR of `irq_out`.

## Operation
- Register decode on `adr[4:2]`; byte lanes honoured via `sel` on writes.
  - 0x00 STATUS: R = pending; W1C.
  - 0x04 ENABLE: RW, bit per channel.
  - 0x08 MODE: RW, 2 bits per channel at `[2i+1:2i]`; 0 LEVEL, 1 RISE, 2 FALL, 3 BOTH.
  - 0x0C RAW: RO, conditioned input sample.
  - 0x10 SET: WO; write 1 sets pending (software trigger); reads 0.
  - Others: read 0, writes ignored, still acknowledged.
- Bits at or above `CHANNELS` (2·`CHANNELS` for MODE) read 0 and are not stored.
- Per channel: `last` always tracks the conditioned sample, whatever the mode, so a MODE write never fabricates an edge.
- The event condition per mode:
  - LEVEL: sample = 1.
  - RISE: sample & ~last.
  - FALL: ~sample & last.
  - BOTH: sample ^ last.
- Pending next = (pending & ~clear) | event | set. Event or SET wins over a simultaneous W1C.
- LEVEL mode: W1C while the input is still high re-asserts pending on the next edge.
- ENABLE only masks outputs; disabled channels still latch pending.
- Reset values:
  - pending, ENABLE, `last`, sync flops = 0.
  - MODE = `RESET_MODE`.
  - `ack`, `dat_o`, `irq_out`, `irq_any` = 0.
  - An input held high through reset therefore raises a RISE/BOTH event after release.

## Timing
- Bus access:
  - `ack` is registered. It asserts the cycle after `cyc & stb` is sampled and is held for 1 cycle.
  - The next access is accepted only after `ack` drops. One access takes 2 cycles; no wait states, no error or retry.
  - Write effects (including W1C and SET) take effect on the same edge that raises `ack`.
  - Read data is registered alongside `ack` and reflects state before that edge.
- Event latency:
  - `irq_in` change → pending at the 1st rising edge without the sync stage, or the 3rd with it.
  - `irq_out` and `irq_any` are combinational from pending and ENABLE, so there is no added delay.
- Pulses shorter than 1 clock (no sync) or 2 clocks (sync) may be missed. No stretching.
- Reset asserted mid-access drops `ack` immediately; the access is lost.

## Configuration
- `WB_INTC_SYNC_EN` defined: a two-flop synchronizer per `irq_in` bit feeds the detector and RAW.
- `WB_INTC_SYNC_EN` undefined: `irq_in` is taken as synchronous to `clk` and feeds the detector directly. Latency is 2 cycles shorter.

## Structure
- Package `intc_pkg`:
  - `intc_mode_t` enum: `INTC_LEVEL`, `INTC_RISE`, `INTC_FALL`, `INTC_BOTH`.
  - Register offset constants: `INTC_STATUS`, `INTC_ENABLE`, `INTC_MODE`, `INTC_RAW`, `INTC_SET`.
- Sub-module `intc_channel`, generated per channel. It holds the optional sync, `last`, the detector and the pending flop. Inputs: mode, clear, set. Outputs: sample, pending.
- The top holds the bus decode, ENABLE/MODE storage and output masking.

## Test plan
- Reset, RISE/BOTH, read-back:
  - Stimulus: `CHANNELS`=4, `RESET_MODE`=32'h55 (all RISE), ENABLE=4'hF. Pulse `irq_in[2]` high for 4 cycles.
  - Required: STATUS reads 4'h4 and `irq_any`=1.
  - Then W1C 4'h4 → STATUS=0 and `irq_any`=0.
  - Then MODE=BOTH on ch2 and drop the input → pending sets again.
- LEVEL re-assert:
  - Stimulus: ch0 in LEVEL, `irq_in[0]` held high, W1C 4'h1.
  - Required: STATUS bit0 reads 1 again on the next access. After the input drops, W1C clears it permanently.
- Simultaneous set/clear:
  - Stimulus: RISE edge on ch1 on the same edge as a W1C of ch1.
  - Required: pending stays 1.
  - Same check with SET 4'h2 plus W1C: pending stays 1.
- Masking:
  - Stimulus: ENABLE=4'h0, edge on ch3.
  - Required: STATUS=4'h8 with `irq_out`=0. Then ENABLE=4'h8 → `irq_out[3]`=1 the same cycle.
- Latency and sync:
  - Stimulus: measure `irq_in` edge to pending with and without `WB_INTC_SYNC_EN`.
  - Required: 3 edges and 1 edge respectively.
  - Also: MODE write with the input static produces no event.
- Bus edge cases:
  - Stimulus: read offset 0x14 → 0 with `ack`. Write upper bits of ENABLE → read back masked to `CHANNELS`.
  - Stimulus: assert `rst_n`=0 during `stb` → `ack` drops, all registers return to reset values.
